// File: rtl/pci_target_burst_pkg.sv
// Shared definitions for the PCI burst memory target: bus commands, FSM states
// and active-low signal levels.
package pci_target_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TURN = 3'd1,
    ST_WAIT = 3'd2,
    ST_DATA = 3'd3,
    ST_DISC = 3'd4
  } state_t;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR);
  endfunction

endpackage

// File: rtl/pci_target_burst_mem.sv
// Word-organised target storage: synchronous byte-masked write, asynchronous read.
// Contents are deliberately not reset.
module pci_target_burst_mem
  import pci_target_burst_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/pci_target_burst.sv
// PCI memory target: base-address decode, linear bursts with byte enables,
// programmable initial wait states and disconnect at the top of memory.
module pci_target_burst
  import pci_target_burst_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_BITS   = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME,
  inout  wire  [31:0] AD,
  input  logic [3:0]  CBE,
  input  logic        IRDY,
  output logic        TRDY,
  output logic        DEVSEL,
  output logic        STOP
);

  localparam int unsigned          DEPTH     = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ONE_WORD  = ADDR_BITS'(1);
  localparam logic [2:0]           WAIT_INIT = 3'(WAIT_STATES);

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   read_q, read_d;
  logic                   single_q, single_d;
  logic [2:0]             wait_q, wait_d;
  logic                   trdy_q, trdy_d;
  logic                   devsel_q, devsel_d;
  logic                   stop_q, stop_d;
  logic                   frame_q;
  logic                   hit_s, claim_s, xfer_s, we_s;
  logic [31:0]            rdata_s;

  // The last word of the region, or a misaligned start, ends the burst with this phase.
  function automatic logic stop_for(input logic [ADDR_BITS-1:0] a, input logic single);
    return ((a == LAST_WORD) || single) ? ASSERT_N : DEASSERT_N;
  endfunction

  assign hit_s   = (AD[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign claim_s = !FRAME && frame_q && hit_s && is_mem_cmd(CBE);
  assign xfer_s  = !IRDY && (trdy_q == ASSERT_N);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    read_d   = read_q;
    single_d = single_q;
    wait_d   = wait_q;
    trdy_d   = trdy_q;
    devsel_d = devsel_q;
    stop_d   = stop_q;
    we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (claim_s) begin
          devsel_d = ASSERT_N;
          addr_d   = AD[ADDR_BITS+1:2];
          read_d   = (CBE == CMD_MEM_RD);
          single_d = (AD[1:0] != 2'b00);
          if (CBE == CMD_MEM_RD) begin
            state_d = ST_TURN;
          end else if (WAIT_INIT == 3'd0) begin
            state_d = ST_DATA;
            trdy_d  = ASSERT_N;
            stop_d  = stop_for(AD[ADDR_BITS+1:2], AD[1:0] != 2'b00);
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (WAIT_INIT == 3'd0) begin
          state_d = ST_DATA;
          trdy_d  = ASSERT_N;
          stop_d  = stop_for(addr_q, single_q);
        end else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (wait_q <= 3'd1) begin
          state_d = ST_DATA;
          wait_d  = 3'd0;
          trdy_d  = ASSERT_N;
          stop_d  = stop_for(addr_q, single_q);
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_DATA: begin
        // FRAME high with IRDY high is illegal and simply holds the phase.
        if (xfer_s) begin
          we_s = !read_q;
          if (FRAME) begin
            state_d  = ST_IDLE;
            trdy_d   = DEASSERT_N;
            devsel_d = DEASSERT_N;
            stop_d   = DEASSERT_N;
          end else if (stop_q == ASSERT_N) begin
            state_d = ST_DISC;
            trdy_d  = DEASSERT_N;
          end else begin
            addr_d = addr_q + ONE_WORD;
            stop_d = stop_for(addr_q + ONE_WORD, single_q);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DISC: begin
        if (FRAME) begin
          state_d  = ST_IDLE;
          devsel_d = DEASSERT_N;
          stop_d   = DEASSERT_N;
        end else begin
          state_d = ST_DISC;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        trdy_d   = DEASSERT_N;
        devsel_d = DEASSERT_N;
        stop_d   = DEASSERT_N;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      read_q   <= 1'b0;
      single_q <= 1'b0;
      wait_q   <= 3'd0;
      trdy_q   <= DEASSERT_N;
      devsel_q <= DEASSERT_N;
      stop_q   <= DEASSERT_N;
      frame_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      single_q <= single_d;
      wait_q   <= wait_d;
      trdy_q   <= trdy_d;
      devsel_q <= devsel_d;
      stop_q   <= stop_d;
      frame_q  <= FRAME;
    end
  end

  pci_target_burst_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (CLK),
    .we    (we_s),
    .be    (~CBE),
    .addr  (addr_q),
    .wdata (AD),
    .rdata (rdata_s)
  );

  // Read data is on the bus only while a read data phase is offered.
  assign AD     = (read_q && (trdy_q == ASSERT_N)) ? rdata_s : {32{1'bz}};
  assign TRDY   = trdy_q;
  assign DEVSEL = devsel_q;
  assign STOP   = stop_q;

endmodule

// File: tb/tb_pci_target_burst.sv
// Directed bench: two targets share one bus (base 0 with no waits, base 0x1000
// with two wait states) driven by a simple initiator.
module tb_pci_target_burst;

  logic        clk = 1'b0;
  logic        rst, frame, irdy, tb_oe, sel;
  logic [3:0]  cbe;
  logic [31:0] tb_ad;
  wire  [31:0] ad;
  logic        trdy0, devsel0, stop0, trdy1, devsel1, stop1;
  logic        trdy_s, devsel_s, stop_s;
  int          checks = 0;
  int          passed = 0;

  assign ad       = tb_oe ? tb_ad : {32{1'bz}};
  assign trdy_s   = sel ? trdy1 : trdy0;
  assign devsel_s = sel ? devsel1 : devsel0;
  assign stop_s   = sel ? stop1 : stop0;

  always #5 clk = ~clk;

  pci_target_burst #(.BASE_ADDR(32'h0000_0000), .ADDR_BITS(4), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RST(rst), .FRAME(frame), .AD(ad), .CBE(cbe), .IRDY(irdy),
    .TRDY(trdy0), .DEVSEL(devsel0), .STOP(stop0));

  pci_target_burst #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4), .WAIT_STATES(2)) dut1 (
    .CLK(clk), .RST(rst), .FRAME(frame), .AD(ad), .CBE(cbe), .IRDY(irdy),
    .TRDY(trdy1), .DEVSEL(devsel1), .STOP(stop1));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic go_idle();
    frame = 1'b1; irdy = 1'b1; tb_oe = 1'b0; cbe = 4'h0;
    step();
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic [3:0] cmd);
    sel = addr[12];
    frame = 1'b0; irdy = 1'b1; tb_oe = 1'b1; tb_ad = addr; cbe = cmd;
    step();
  endtask

  // Single-phase transaction; returns the word read (don't-care for writes).
  task automatic single(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, output logic [31:0] rd);
    logic done;
    done = 1'b0;
    rd = 32'h0;
    addr_phase(addr, wr ? 4'b0111 : 4'b0110);
    check("devsel_claim", {31'h0, devsel_s}, 32'h0);
    frame = 1'b1; irdy = 1'b0; cbe = be;
    if (wr) tb_ad = data;
    else tb_oe = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (trdy_s == 1'b0) begin
        rd = ad;
        done = 1'b1;
      end
      step();
    end
    check("xfer_done", {31'h0, done}, 32'h1);
    check("release", {29'h0, trdy_s, devsel_s, stop_s}, 32'h7);
    go_idle();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] burst[4];
    burst[0] = 32'h0000_0011; burst[1] = 32'h0000_0022;
    burst[2] = 32'h0000_0033; burst[3] = 32'h0000_0044;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h0000_F0F0, 4'b0000, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h0000_F0F0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0000, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'b1010, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'hAA22_CC44};
    vecs[5]  = '{1'b1, 32'h0000_1008, 32'hCAFE_0001, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_1008, 32'h0,         4'b0000, 32'hCAFE_0001};
    vecs[7]  = '{1'b1, 32'h0000_0038, 32'hE0E0_E0E0, 4'b0000, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_003C, 32'hF0F0_F00F, 4'b0000, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_003C, 32'h0000_5500, 4'b1101, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_003C, 32'h0,         4'b0000, 32'hF0F0_550F};

    sel = 1'b0; tb_ad = 32'h0; tb_oe = 1'b0; cbe = 4'h0; frame = 1'b1; irdy = 1'b1;
    rst = 1'b0;
    step(); step();
    check("reset_dut0", {29'h0, trdy0, devsel0, stop0}, 32'h7);
    check("reset_dut1", {29'h0, trdy1, devsel1, stop1}, 32'h7);
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      single(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
    end

    // Burst write of four words, initiator stall on the second phase.
    addr_phase(32'h0000_0000, 4'b0111);
    cbe = 4'b0000; irdy = 1'b0; tb_ad = burst[0];
    check("bw_trdy", {31'h0, trdy0}, 32'h0);
    step();
    irdy = 1'b1; tb_ad = 32'hDEAD_BEEF;
    step();
    irdy = 1'b0; tb_ad = burst[1]; step();
    tb_ad = burst[2]; step();
    frame = 1'b1; tb_ad = burst[3]; step();
    check("bw_release", {29'h0, trdy0, devsel0, stop0}, 32'h7);
    go_idle();

    // Burst read back of the same four words.
    addr_phase(32'h0000_0000, 4'b0110);
    frame = 1'b0; irdy = 1'b0; tb_oe = 1'b0; cbe = 4'h0;
    check("br_turn_trdy", {31'h0, trdy0}, 32'h1);
    step();
    for (int i = 0; i < 4; i++) begin
      frame = (i == 3);
      check($sformatf("br_trdy%0d", i), {31'h0, trdy0}, 32'h0);
      check($sformatf("br_data%0d", i), ad, burst[i]);
      step();
    end
    check("br_release", {29'h0, trdy0, devsel0, stop0}, 32'h7);
    go_idle();

    // Two initial wait states after the turnaround edge.
    addr_phase(32'h0000_1008, 4'b0110);
    frame = 1'b1; irdy = 1'b0; tb_oe = 1'b0; cbe = 4'h0;
    check("ws_devsel", {31'h0, devsel1}, 32'h0);
    check("ws_trdy_n", {31'h0, trdy1}, 32'h1);
    step();
    check("ws_trdy_n1", {31'h0, trdy1}, 32'h1);
    step();
    check("ws_trdy_n2", {31'h0, trdy1}, 32'h1);
    step();
    check("ws_trdy_n3", {31'h0, trdy1}, 32'h0);
    check("ws_data", ad, 32'hCAFE_0001);
    step();
    check("ws_release", {29'h0, trdy1, devsel1, stop1}, 32'h7);
    go_idle();

    // Burst from word 14 with FRAME held: disconnect with word 15.
    addr_phase(32'h0000_0038, 4'b0110);
    frame = 1'b0; irdy = 1'b0; tb_oe = 1'b0; cbe = 4'h0;
    step();
    check("top_w14", ad, 32'hE0E0_E0E0);
    check("top_stop14", {30'h0, trdy0, stop0}, 32'h1);
    step();
    check("top_w15", ad, 32'hF0F0_550F);
    check("top_stop15", {30'h0, trdy0, stop0}, 32'h0);
    step();
    check("top_disc", {29'h0, trdy0, devsel0, stop0}, 32'h4);
    step();
    check("top_no_3rd", {29'h0, trdy0, devsel0, stop0}, 32'h4);
    frame = 1'b1; irdy = 1'b1;
    step();
    check("top_release", {29'h0, trdy0, devsel0, stop0}, 32'h7);
    go_idle();

    // Misaligned start: one transfer then disconnect.
    addr_phase(32'h0000_0005, 4'b0110);
    frame = 1'b0; irdy = 1'b0; tb_oe = 1'b0; cbe = 4'h0;
    step();
    check("mis_data", ad, 32'h0000_0022);
    check("mis_stop", {30'h0, trdy0, stop0}, 32'h0);
    step();
    check("mis_disc", {29'h0, trdy0, devsel0, stop0}, 32'h4);
    frame = 1'b1; irdy = 1'b1;
    step();
    check("mis_release", {29'h0, trdy0, devsel0, stop0}, 32'h7);
    go_idle();

    // Address outside both regions.
    addr_phase(32'h0001_0000, 4'b0110);
    check("miss_devsel", {30'h0, devsel0, devsel1}, 32'h3);
    frame = 1'b1; irdy = 1'b0; tb_oe = 1'b0;
    step();
    check("miss_devsel2", {30'h0, devsel0, devsel1}, 32'h3);
    go_idle();

    // Reset in the middle of a read burst.
    addr_phase(32'h0000_0000, 4'b0110);
    frame = 1'b0; irdy = 1'b0; tb_oe = 1'b0; cbe = 4'h0;
    step();
    check("rst_pre_trdy", {31'h0, trdy0}, 32'h0);
    rst = 1'b0;
    step();
    check("rst_outputs", {29'h0, trdy0, devsel0, stop0}, 32'h7);
    tb_oe = 1'b1; tb_ad = 32'h0;
    #1;
    check("rst_ad_released", ad, 32'h0);
    step();
    check("rst_outputs2", {29'h0, trdy0, devsel0, stop0}, 32'h7);
    rst = 1'b1;
    go_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
